// File: rtl/scale_ctrl.sv
// -----------------------------------------------------------------------------
// scale_ctrl
//
// Display scale-mode controller plus frame-buffer address generator.
//
// A debounced button advances the scale mode through 0 -> 2 -> 3 -> 0. The
// raster position (hcount_in, vcount_in) is mapped through the current mode
// into a 240x320 frame-buffer read address, with two cycles of latency.
//
// Build option:
//   SCALE_FRAME_SYNC_EN  defined   : a press only records a target mode. The
//                                    target is applied on the next
//                                    new_frame_in pulse, so the picture never
//                                    changes scale mid-frame.
//   SCALE_FRAME_SYNC_EN  undefined : a press applies the next mode at once and
//                                    new_frame_in is ignored.
//
// Parameters:
//   RESET_SCALE        scale mode loaded on reset (legal values: 0, 2, 3)
//
// Ports:
//   clk_in             pixel clock (single clock domain)
//   rst_in             synchronous, active-high reset
//   btn_pulse_in       one-cycle request to advance the scale mode
//   new_frame_in       one-cycle pulse at the start of each frame
//   hcount_in[10:0]    raster column
//   vcount_in[9:0]     raster row
//   scale_out[1:0]     scale mode currently applied
//   pending_out        high while a mode change waits for the next frame
//   scale_changed_out  one-cycle pulse in the cycle after a mode is applied
//   addr_out[16:0]     frame-buffer read address (0 when not valid)
//   addr_valid_out     qualifies addr_out
// -----------------------------------------------------------------------------
module scale_ctrl #(
  parameter logic [1:0] RESET_SCALE = 2'd0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        btn_pulse_in,
  input  logic        new_frame_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [1:0]  scale_out,
  output logic        pending_out,
  output logic        scale_changed_out,
  output logic [16:0] addr_out,
  output logic        addr_valid_out
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Mode sequence 0 -> 2 -> 3 -> 0. Mode 1 is never produced; should it ever
  // appear it is pushed back into the legal sequence.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      2'd0:    next_mode = 2'd2;
      2'd2:    next_mode = 2'd3;
      2'd3:    next_mode = 2'd0;
      default: next_mode = 2'd2;
    endcase
  endfunction

  state_t     state_q, state_nxt;
  logic [1:0] scale_q, scale_nxt;
  logic       load;
  logic       changed_q;

`ifdef SCALE_FRAME_SYNC_EN
  logic [1:0] target_q, target_nxt;

  always_comb begin
    state_nxt  = state_q;
    scale_nxt  = scale_q;
    target_nxt = target_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        // A press in IDLE always waits for the next frame, even if a frame
        // pulse coincides with it.
        if (btn_pulse_in) begin
          target_nxt = next_mode(scale_q);
          state_nxt  = PENDING;
        end
      end
      PENDING: begin
        if (btn_pulse_in && new_frame_in) begin
          // The coincident press counts before the frame applies it.
          scale_nxt  = next_mode(target_q);
          target_nxt = next_mode(target_q);
          load       = 1'b1;
          state_nxt  = IDLE;
        end else if (btn_pulse_in) begin
          target_nxt = next_mode(target_q);
        end else if (new_frame_in) begin
          scale_nxt = target_q;
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      target_q <= RESET_SCALE;
    end else begin
      target_q <= target_nxt;
    end
  end
`else
  // Immediate mode: frame pulses play no part.
  logic unused_new_frame;
  assign unused_new_frame = new_frame_in;

  always_comb begin
    state_nxt = IDLE;
    scale_nxt = scale_q;
    load      = 1'b0;
    if (btn_pulse_in) begin
      scale_nxt = next_mode(scale_q);
      load      = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      scale_q   <= RESET_SCALE;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      scale_q   <= scale_nxt;
      changed_q <= load;
    end
  end

  assign scale_out         = scale_q;
  assign pending_out       = (state_q == PENDING);
  assign scale_changed_out = changed_q;

  // ---------------------------------------------------------------------------
  // Input -> stage 1: map raster position into frame-buffer coordinates using
  // the mode held in scale_q, so a mode change reaches this stage one cycle
  // after scale_out updates while pixels already in flight keep the old mode.
  // ---------------------------------------------------------------------------
  logic [7:0] sh_d, sh_p1;
  logic [8:0] sv_d, sv_p1;
  logic       vld_d, vld_p1;

  always_comb begin
    sh_d  = hcount_in[7:0];
    sv_d  = vcount_in[8:0];
    vld_d = (hcount_in < 11'd240) && (vcount_in < 10'd320);
    case (scale_q)
      2'd2: begin
        sh_d  = hcount_in[9:2];
        sv_d  = vcount_in[9:1];
        vld_d = (hcount_in < 11'd960) && (vcount_in < 10'd640);
      end
      2'd3: begin
        sh_d  = hcount_in[8:1];
        sv_d  = vcount_in[9:1];
        vld_d = (hcount_in < 11'd480) && (vcount_in < 10'd640);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sh_p1  <= '0;
      sv_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      sh_p1  <= sh_d;
      sv_p1  <= sv_d;
      vld_p1 <= vld_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 -> stage 2: linear address. Valid coordinates keep sv <= 319 and
  // sh <= 239, so the result tops out at 76799 and fits 17 bits. Invalid
  // pixels drive a zero address.
  // ---------------------------------------------------------------------------
  logic [16:0] addr_p2;
  logic        vld_p2;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      addr_p2 <= vld_p1 ? (17'(sv_p1) * 17'd240 + 17'(sh_p1)) : 17'd0;
      vld_p2  <= vld_p1;
    end
  end

  assign addr_out       = addr_p2;
  assign addr_valid_out = vld_p2;

endmodule

// File: tb/tb_scale_ctrl.sv
module tb_scale_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn = 1'b0;
  logic        nf  = 1'b0;
  logic [10:0] hc  = '0;
  logic [9:0]  vc  = '0;
  logic [1:0]  scale;
  logic        pending;
  logic        changed;
  logic [16:0] addr;
  logic        avld;

  int n_checks = 0;
  int n_errors = 0;

  scale_ctrl #(.RESET_SCALE(2'd0)) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .btn_pulse_in      (btn),
    .new_frame_in      (nf),
    .hcount_in         (hc),
    .vcount_in         (vc),
    .scale_out         (scale),
    .pending_out       (pending),
    .scale_changed_out (changed),
    .addr_out          (addr),
    .addr_valid_out    (avld)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  mode;
    logic [10:0] h;
    logic [9:0]  v;
    logic [16:0] exp_addr;
    logic        exp_vld;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One cycle of control inputs; returns #1 after the sampling edge.
  task automatic pulse(input logic b, input logic f);
    @(negedge clk);
    btn = b;
    nf  = f;
    @(posedge clk);
    #1;
    btn = 1'b0;
    nf  = 1'b0;
  endtask

  // Reset with both control requests asserted to exercise reset priority.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b1;
    nf  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    btn = 1'b0;
    nf  = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    int presses;
    presses = (m == 2'd2) ? 1 : (m == 2'd3) ? 2 : 0;
    do_reset();
    for (int i = 0; i < presses; i++) begin
      pulse(1'b1, 1'b0);
`ifdef SCALE_FRAME_SYNC_EN
      pulse(1'b0, 1'b1);
`endif
    end
  endtask

  task automatic drive_pix(input logic [10:0] h, input logic [9:0] v);
    @(negedge clk);
    hc = h;
    vc = v;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{2'd0, 11'd239, 10'd319, 17'd76799, 1'b1};
    vecs[1]  = '{2'd0, 11'd240, 10'd319, 17'd0,     1'b0};
    vecs[2]  = '{2'd0, 11'd239, 10'd320, 17'd0,     1'b0};
    vecs[3]  = '{2'd0, 11'd10,  10'd5,   17'd1210,  1'b1};
    vecs[4]  = '{2'd0, 11'd0,   10'd0,   17'd0,     1'b1};
    vecs[5]  = '{2'd2, 11'd959, 10'd639, 17'd76799, 1'b1};
    vecs[6]  = '{2'd2, 11'd960, 10'd639, 17'd0,     1'b0};
    vecs[7]  = '{2'd2, 11'd8,   10'd4,   17'd482,   1'b1};
    vecs[8]  = '{2'd2, 11'd100, 10'd640, 17'd0,     1'b0};
    vecs[9]  = '{2'd3, 11'd100, 10'd50,  17'd6050,  1'b1};
    vecs[10] = '{2'd3, 11'd479, 10'd639, 17'd76799, 1'b1};
    vecs[11] = '{2'd3, 11'd480, 10'd0,   17'd0,     1'b0};

    // Reset state; pixel inputs held at the last valid mode-0 position.
    hc = 11'd239;
    vc = 10'd319;
    do_reset();
    check("rst_scale",   32'(scale),   32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_changed", 32'(changed), 32'd0);
    check("rst_addr",    32'(addr),    32'd0);
    check("rst_vld",     32'(avld),    32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("post_rst_addr", 32'(addr), 32'd76799);
    check("post_rst_vld",  32'(avld), 32'd1);

    // Address table, one mode setup per change of mode.
    begin
      logic [1:0] cur;
      cur = 2'd1;
      for (int i = 0; i < 12; i++) begin
        if (vecs[i].mode != cur) begin
          set_mode(vecs[i].mode);
          cur = vecs[i].mode;
          check($sformatf("mode_set_%0d", i), 32'(scale), 32'(vecs[i].mode));
        end
        drive_pix(vecs[i].h, vecs[i].v);
        @(posedge clk);
        @(posedge clk);
        #1;
        check($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].exp_addr));
        check($sformatf("vec%0d_vld", i),  32'(avld), 32'(vecs[i].exp_vld));
      end
    end

    // Latency: mode 3, address appears exactly two edges after the inputs.
    set_mode(2'd3);
    drive_pix(11'd0, 10'd0);
    @(posedge clk);
    @(posedge clk);
    drive_pix(11'd100, 10'd50);
    @(posedge clk);
    #1;
    check("lat_1cyc_addr", 32'(addr), 32'd0);
    @(posedge clk);
    #1;
    check("lat_2cyc_addr", 32'(addr), 32'd6050);

`ifdef SCALE_FRAME_SYNC_EN
    // One press, three frame pulses: applied only at the first pulse.
    do_reset();
    pulse(1'b1, 1'b0);
    check("sync_pend", 32'(pending), 32'd1);
    check("sync_pend_scale", 32'(scale), 32'd0);
    pulse(1'b0, 1'b0);
    check("sync_still_pend", 32'(pending), 32'd1);
    pulse(1'b0, 1'b1);
    check("sync_f1_scale",   32'(scale),   32'd2);
    check("sync_f1_changed", 32'(changed), 32'd1);
    check("sync_f1_pend",    32'(pending), 32'd0);
    pulse(1'b0, 1'b1);
    check("sync_f2_changed", 32'(changed), 32'd0);
    pulse(1'b0, 1'b1);
    check("sync_f3_scale",   32'(scale),   32'd2);
    check("sync_f3_changed", 32'(changed), 32'd0);

    // Three presses wrap back to mode 0.
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("wrap_pend_scale", 32'(scale), 32'd0);
    pulse(1'b0, 1'b1);
    check("wrap_scale", 32'(scale),   32'd0);
    check("wrap_pend",  32'(pending), 32'd0);

    // Press in IDLE together with a frame pulse waits for the next frame.
    do_reset();
    pulse(1'b1, 1'b1);
    check("idle_coinc_scale", 32'(scale),   32'd0);
    check("idle_coinc_pend",  32'(pending), 32'd1);
    pulse(1'b0, 1'b1);
    check("idle_coinc_apply", 32'(scale), 32'd2);

    // PENDING with target 2, press + frame together -> mode 3, then reset.
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    check("coinc_scale", 32'(scale),   32'd3);
    check("coinc_pend",  32'(pending), 32'd0);
    check("coinc_chg",   32'(changed), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("coinc_rst_scale", 32'(scale),   32'd0);
    check("coinc_rst_pend",  32'(pending), 32'd0);

    // Reset while pending discards the target.
    do_reset();
    pulse(1'b1, 1'b0);
    do_reset();
    check("disc_pend", 32'(pending), 32'd0);
    pulse(1'b0, 1'b1);
    check("disc_scale", 32'(scale), 32'd0);
`else
    // Immediate build: each press applies the next mode on the next edge.
    do_reset();
    pulse(1'b1, 1'b0);
    check("imm_p1_scale", 32'(scale),   32'd2);
    check("imm_p1_chg",   32'(changed), 32'd1);
    check("imm_p1_pend",  32'(pending), 32'd0);
    pulse(1'b0, 1'b0);
    check("imm_chg_drop", 32'(changed), 32'd0);
    pulse(1'b1, 1'b0);
    check("imm_p2_scale", 32'(scale), 32'd3);
    pulse(1'b1, 1'b0);
    check("imm_p3_scale", 32'(scale),   32'd0);
    check("imm_p3_pend",  32'(pending), 32'd0);
    pulse(1'b0, 1'b1);
    check("imm_nf_scale", 32'(scale),   32'd0);
    check("imm_nf_chg",   32'(changed), 32'd0);
    check("imm_nf_pend",  32'(pending), 32'd0);
    pulse(1'b1, 1'b1);
    check("imm_both_scale", 32'(scale), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/scale_ctrl.md
SCALE_CTRL -- requirements
Module: scale_ctrl

Interface
REQ-001 SHALL have parameter RESET_SCALE, default 2'd0, the scale mode loaded on reset; legal values are 0, 2 and 3.
REQ-002 SHALL have port clk_in, input, 1 bit, the pixel clock; one clock domain only.
REQ-003 SHALL have port rst_in, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port btn_pulse_in, input, 1 bit, a one-cycle debounced request to advance the scale mode.
REQ-005 SHALL have port new_frame_in, input, 1 bit, a one-cycle pulse at the start of each frame.
REQ-006 SHALL have port hcount_in, input, 11 bits, the raster column.
REQ-007 SHALL have port vcount_in, input, 10 bits, the raster row.
REQ-008 SHALL have port scale_out, output, 2 bits, the currently applied scale mode.
REQ-009 SHALL have port pending_out, output, 1 bit, high while a mode change is waiting to be applied.
REQ-010 SHALL have port scale_changed_out, output, 1 bit, a one-cycle pulse in the cycle after a new mode is applied.
REQ-011 SHALL have port addr_out, output, 17 bits, the 240x320 frame-buffer read address.
REQ-012 SHALL have port addr_valid_out, output, 1 bit, qualifying addr_out.

Function
REQ-013 SHALL advance the mode in the sequence 0 -> 2 -> 3 -> 0; scale_out SHALL never equal 1.
REQ-014 SHALL implement a two-state FSM: IDLE and PENDING.
REQ-015 In IDLE, btn_pulse_in SHALL set target = next(scale_out) and move the FSM to PENDING; this holds even when new_frame_in is high in the same cycle, so the change is applied at the following frame.
REQ-016 In PENDING, btn_pulse_in without new_frame_in SHALL set target = next(target); presses accumulate with wrap-around.
REQ-017 In PENDING, new_frame_in without btn_pulse_in SHALL load scale_out = target and return the FSM to IDLE.
REQ-018 In PENDING, btn_pulse_in and new_frame_in in the same cycle SHALL load scale_out = next(target) and return the FSM to IDLE.
REQ-019 pending_out SHALL be high exactly while the FSM is in PENDING.
REQ-020 Stage 1 SHALL register scaled coordinates (sh, sv) and valid v1 from the current scale_out:
  - mode 0: sh = h, sv = v; valid when h < 240 and v < 320.
  - mode 2: sh = h >> 2, sv = v >> 1; valid when h < 960 and v < 640.
  - mode 3: sh = h >> 1, sv = v >> 1; valid when h < 480 and v < 640.
REQ-021 Stage 2 SHALL register addr_out = sv*240 + sh at 17 bits, together with addr_valid_out = v1.
REQ-022 Latency SHALL be exactly 2 cycles from hcount_in/vcount_in to addr_out/addr_valid_out.
REQ-023 When addr_valid_out is 0, addr_out SHALL be 0.
REQ-024 The maximum address SHALL be 76799; no overflow is possible.
REQ-025 A mode change SHALL affect stage 1 starting in the cycle after scale_out updates; pixels already in the pipeline SHALL complete with the old mode.

Reset
REQ-026 rst_in SHALL force the following on the next clock edge:
  - FSM = IDLE; target = RESET_SCALE; scale_out = RESET_SCALE.
  - pending_out = 0; scale_changed_out = 0.
  - addr_out = 0; addr_valid_out = 0.
  - Both pipeline stages cleared.
REQ-027 rst_in SHALL have priority over btn_pulse_in and new_frame_in in the same cycle.
REQ-028 Reset asserted while the FSM is in PENDING SHALL discard the pending target.

Configuration
REQ-029 Macro SCALE_FRAME_SYNC_EN SHALL select when mode changes are applied.
REQ-030 When SCALE_FRAME_SYNC_EN is defined, behaviour SHALL be as REQ-014 to REQ-019: changes are deferred to new_frame_in.
REQ-031 When SCALE_FRAME_SYNC_EN is undefined:
  - btn_pulse_in SHALL load scale_out = next(scale_out) on the next edge.
  - The FSM SHALL remain in IDLE and pending_out SHALL be constant 0.
  - new_frame_in SHALL be ignored.
  - scale_changed_out SHALL pulse one cycle after each press.

Verification
REQ-032 Reset with RESET_SCALE=0, hcount=239, vcount=319 -> two cycles later addr_out=76799, addr_valid_out=1; with hcount=240 -> addr_valid_out=0, addr_out=0.
REQ-033 Mode 2, hcount=959, vcount=639 -> addr_out = 319*240 + 239 = 76799; with hcount=960 -> addr_valid_out=0.
REQ-034 Mode 3, hcount=100, vcount=50 -> addr_out = 25*240 + 50 = 6050, exactly 2 cycles later.
REQ-035 Sync build, mode 0: one press, then three new_frame_in pulses -> pending_out=1 until the first pulse, then scale_out=2 and scale_changed_out pulses once; with three presses before new_frame_in -> scale_out=0 (wrap-around).
REQ-036 Sync build, PENDING with target=2: press and new_frame_in in the same cycle -> scale_out=3, FSM in IDLE; then rst_in in the next cycle -> scale_out=RESET_SCALE, pending_out=0.
REQ-037 Non-sync build, mode 3: one press -> scale_out=0 the next cycle, pending_out stays 0.
